// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA raster timing generator (pixel strobe, x/y
//            counters, video_on, hsync/vsync, line_end, frame_start).
//            Optional completed-frame counter enabled by VGA_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned DIV      = 4,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 10,
    parameter int unsigned FCW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    output logic          pixel_tick,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          video_on,
    output logic          hsync,
    output logic          vsync,
    output logic          line_end,
    output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [FCW-1:0] frame_cnt
`endif
);

    localparam logic [31:0] c_h_total    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [31:0] c_v_total    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [31:0] c_hs_start   = H_ACTIVE + H_FP;
    localparam logic [31:0] c_hs_end     = H_ACTIVE + H_FP + H_SYNC;
    localparam logic [31:0] c_vs_start   = V_ACTIVE + V_FP;
    localparam logic [31:0] c_vs_end     = V_ACTIVE + V_FP + V_SYNC;
    localparam logic [CW-1:0] c_h_last   = CW'(c_h_total - 32'd1);
    localparam logic [CW-1:0] c_v_last   = CW'(c_v_total - 32'd1);

    generate
        if (DIV == 0 || CW == 0 || CW > 31 || FCW == 0 || H_ACTIVE == 0 ||
            V_ACTIVE == 0 || c_h_total > (32'd1 << CW) ||
            c_v_total > (32'd1 << CW)) begin : g_param_check
            $error("vga_timing_gen: invalid parameter set");
        end
    endgenerate

    logic          w_tick;
    logic [CW-1:0] w_x_next;
    logic [CW-1:0] w_y_next;
    logic [31:0]   w_x_ext;
    logic [31:0]   w_y_ext;
    logic          w_frame_wrap;
    logic          w_hs_act;
    logic          w_vs_act;

    logic [CW-1:0] r_pixel_x;
    logic [CW-1:0] r_pixel_y;
    logic          r_video_on;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_line_end;
    logic          r_frame_start;

    // Clock divider: the strobe marks the last system clock of each pixel.
    generate
        if (DIV > 1) begin : g_div
            localparam int unsigned     c_dw       = $clog2(DIV);
            localparam logic [c_dw-1:0] c_div_last = c_dw'(DIV - 1);
            logic [c_dw-1:0] r_div;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_div <= '0;
                end else if (r_div == c_div_last) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + c_dw'(1);
                end
            end

            assign w_tick = (r_div == c_div_last);
        end else begin : g_no_div
            assign w_tick = 1'b1;
        end
    endgenerate

    always_comb begin
        w_x_next = r_pixel_x;
        w_y_next = r_pixel_y;
        if (w_tick) begin
            if (r_pixel_x == c_h_last) begin
                w_x_next = '0;
                if (r_pixel_y == c_v_last) begin
                    w_y_next = '0;
                end else begin
                    w_y_next = r_pixel_y + CW'(1);
                end
            end else begin
                w_x_next = r_pixel_x + CW'(1);
            end
        end
    end

    assign w_frame_wrap = w_tick && (r_pixel_x == c_h_last) && (r_pixel_y == c_v_last);

    // Flags are decoded from the next-state counters so that, once
    // registered, they switch on the same edge as pixel_x/pixel_y.
    assign w_x_ext  = {{(32 - CW){1'b0}}, w_x_next};
    assign w_y_ext  = {{(32 - CW){1'b0}}, w_y_next};
    assign w_hs_act = (w_x_ext >= c_hs_start) && (w_x_ext < c_hs_end);
    assign w_vs_act = (w_y_ext >= c_vs_start) && (w_y_ext < c_vs_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_video_on    <= 1'b1;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pixel_x     <= w_x_next;
            r_pixel_y     <= w_y_next;
            r_video_on    <= (w_x_ext < H_ACTIVE) && (w_y_ext < V_ACTIVE);
            r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
            r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
            r_line_end    <= (w_x_next == c_h_last);
            r_frame_start <= w_frame_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [FCW-1:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + FCW'(1);
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign pixel_tick  = w_tick;
    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign video_on    = r_video_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_end    = r_line_end;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Randomised reset/run bench for vga_timing_gen against an
//            arithmetic raster model (three parameter sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       a_tick, a_von, a_hs, a_vs, a_le, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_von, b_hs, b_vs, b_le, b_fs;
    logic [9:0] b_x, b_y;
    logic       c_tick, c_von, c_hs, c_vs, c_le, c_fs;
    logic [9:0] c_x, c_y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] a_fc;
    logic [1:0]  b_fc;
    logic [1:0]  c_fc;
`endif

    int     checks = 0;
    int     errors = 0;
    longint t      = 0;
    bit     armed  = 1'b0;

    // Default 640x480 timing, DIV=4.
    vga_timing_gen u_dut_a (
        .clk(clk), .reset(reset), .pixel_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
        .video_on(a_von), .hsync(a_hs), .vsync(a_vs), .line_end(a_le), .frame_start(a_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(a_fc)
`endif
    );

    // Tiny raster, DIV=1, active-high syncs: 14 clocks/line, 98 clocks/frame.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .CW(10), .FCW(2)
    ) u_dut_b (
        .clk(clk), .reset(reset), .pixel_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
        .video_on(b_von), .hsync(b_hs), .vsync(b_vs), .line_end(b_le), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(b_fc)
`endif
    );

    // Mid raster 32x17, DIV=3: 1632 clocks/frame.
    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .DIV(3), .HS_POL(1'b0), .VS_POL(1'b0), .CW(10), .FCW(2)
    ) u_dut_c (
        .clk(clk), .reset(reset), .pixel_tick(c_tick), .pixel_x(c_x), .pixel_y(c_y),
        .video_on(c_von), .hsync(c_hs), .vsync(c_vs), .line_end(c_le), .frame_start(c_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(c_fc)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // Raster position from elapsed clocks: pixel index = t/div, then x/y by modulo.
    function automatic logic [37:0] ref_out(input longint tt, input int div,
                                            input int ha, input int hfp, input int hsw, input int hbp,
                                            input int va, input int vfp, input int vsw, input int vbp,
                                            input bit hp, input bit vp);
        longint p, ht, vt, x, y;
        logic   tick, von, hs, vs, le, fs;
        p    = tt / div;
        ht   = ha + hfp + hsw + hbp;
        vt   = va + vfp + vsw + vbp;
        x    = p % ht;
        y    = (p / ht) % vt;
        tick = ((tt % div) == div - 1);
        fs   = (p > 0) && (p % (ht * vt) == 0) && (tt % div == 0);
        von  = (x < ha) && (y < va);
        hs   = (x >= ha + hfp && x < ha + hfp + hsw) ? hp : !hp;
        vs   = (y >= va + vfp && y < va + vfp + vsw) ? vp : !vp;
        le   = (x == ht - 1);
        return {tick, von, hs, vs, le, fs, x[15:0], y[15:0]};
    endfunction

    function automatic longint ref_frames(input longint tt, input int div, input longint frame_px, input int fcw);
        return ((tt / div) / frame_px) % (longint'(1) << fcw);
    endfunction

    function automatic logic [37:0] pack(input logic tick, input logic von, input logic hs, input logic vs,
                                         input logic le, input logic fs, input logic [9:0] x, input logic [9:0] y);
        return {tick, von, hs, vs, le, fs, 6'b0, x, 6'b0, y};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            t     <= 0;
            armed <= 1'b1;
        end else begin
            t <= t + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check_val("A_raster", pack(a_tick, a_von, a_hs, a_vs, a_le, a_fs, a_x, a_y),
                      ref_out(t, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
            check_val("B_raster", pack(b_tick, b_von, b_hs, b_vs, b_le, b_fs, b_x, b_y),
                      ref_out(t, 1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1));
            check_val("C_raster", pack(c_tick, c_von, c_hs, c_vs, c_le, c_fs, c_x, c_y),
                      ref_out(t, 3, 20, 3, 5, 4, 10, 2, 3, 2, 1'b0, 1'b0));
`ifdef VGA_FRAME_CNT_EN
            check_val("A_fcnt", a_fc, ref_frames(t, 4, 800 * 525, 16));
            check_val("B_fcnt", b_fc, ref_frames(t, 1, 98, 2));
            check_val("C_fcnt", c_fc, ref_frames(t, 3, 544, 2));
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  a_hs_low, a_le_cnt, b_fs_cnt, b_vs_hi, c_fs_cnt;
        bit  found;
        a_hs_low = 0; a_le_cnt = 0; b_fs_cnt = 0; b_vs_hi = 0; c_fs_cnt = 0;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_a_x", a_x, 0);
        check_val("rst_a_y", a_y, 0);
        check_val("rst_a_von", a_von, 1);
        check_val("rst_a_hs", a_hs, 1);
        check_val("rst_a_vs", a_vs, 1);
        check_val("rst_a_le", a_le, 0);
        check_val("rst_a_fs", a_fs, 0);
        check_val("rst_a_tick", a_tick, 0);
        check_val("rst_b_tick", b_tick, 1);
        check_val("rst_b_hs", b_hs, 0);
        reset = 1'b0;

        // One full default line: 800 pixels * 4 clocks.
        for (int i = 1; i <= 3200; i++) begin
            @(negedge clk);
            if (i == 3) check_val("a_x_before_adv", a_x, 0);
            if (i == 4) check_val("a_x_first_adv", a_x, 1);
            a_hs_low += (a_hs == 1'b0) ? 1 : 0;
            a_le_cnt += (a_le == 1'b1) ? 1 : 0;
            b_fs_cnt += (b_fs == 1'b1) ? 1 : 0;
            b_vs_hi  += (b_vs == 1'b1) ? 1 : 0;
            c_fs_cnt += (c_fs == 1'b1) ? 1 : 0;
        end
        check_val("a_hsync_low_clks", a_hs_low, 384);
        check_val("a_line_end_clks", a_le_cnt, 4);
        check_val("a_y_after_line", a_y, 1);
        check_val("a_x_after_line", a_x, 0);
        check_val("b_frame_starts", b_fs_cnt, 32);
        check_val("b_vsync_clks", b_vs_hi, 448);
        check_val("c_frame_starts", c_fs_cnt, 1);

        // Random run lengths interleaved with random-length resets.
        for (int s = 0; s < 4; s++) begin
            repeat ($urandom_range(300, 6000)) @(negedge clk);
            reset = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            reset = 1'b0;
        end

        // Reset while C sits inside both sync pulses.
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (c_x == 10'd25 && c_y == 10'd12) found = 1'b1;
        end
        check_val("c_reach_sync", found, 1);
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_rst_c_x", c_x, 0);
        check_val("mid_rst_c_y", c_y, 0);
        check_val("mid_rst_c_hs", c_hs, 1);
        check_val("mid_rst_c_vs", c_vs, 1);
        check_val("mid_rst_c_fs", c_fs, 0);
        check_val("mid_rst_c_von", c_von, 1);
        reset = 1'b0;

        b_fs_cnt = 0;
        for (int i = 1; i <= 500; i++) begin
            @(negedge clk);
            b_fs_cnt += (b_fs == 1'b1) ? 1 : 0;
`ifdef VGA_FRAME_CNT_EN
            if (i % 98 == 50) check_val("b_fcnt_seq", b_fc, (i / 98) % 4);
`endif
        end
        check_val("b_five_frames", b_fs_cnt, 5);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
